mem_wb_skid_stage: RTL and testbench
====================================

# mem_wb_skid_stage

Parametrised pipeline-boundary register carrying an instruction word plus NUM_DATA result lanes (e.g. ALU result and memory read data) between two processor stages. It adds a valid/ready handshake with a 2-entry skid buffer, so that back-pressure from the downstream stage never forms a combinational path to the upstream stage. It also provides a synchronous flush for bubble insertion on branch/hazard recovery. It is the drop-in successor for the fixed-width MEM/WB stage register.

## Interface

Parameters:
- INSTR_W, 20, instruction word width
- DATA_W, 20, width of one data lane
- NUM_DATA, 2, number of data lanes; lane k occupies bits [k*DATA_W +: DATA_W]

Ports:
- clock  input  1  rising-edge clock; only clock domain
- reset  input  1  asynchronous, active-high; clears all state
- flush  input  1  synchronous flush; discards all stored entries
- in_valid  input  1  upstream presents a valid entry
- in_ready  output  1  stage can accept an entry this cycle
- in_instr  input  INSTR_W  upstream instruction
- in_data  input  NUM_DATA*DATA_W  upstream data lanes, flat
- out_valid  output  1  main entry valid
- out_ready  input  1  downstream consumes the main entry this cycle
- out_instr  output  INSTR_W  main-entry instruction
- out_data  output  NUM_DATA*DATA_W  main-entry data lanes
- occupancy  output  2  entries held: 0, 1 or 2

## Operation

- Storage:
  - main entry drives out_instr/out_data directly from flops.
  - skid entry is hidden.
- Transfer rules:
  - accept = in_valid & in_ready.
  - consume = out_valid & out_ready.
- States: EMPTY (occupancy 0), MAIN (1), SKID (2).
- in_ready = (state != SKID), decoded from the state register only.
- out_valid = (state != EMPTY).
- EMPTY:
  - accept -> main <= input, go MAIN.
  - out_ready is ignored.
- MAIN:
  - accept & consume -> main <= input, stay MAIN.
  - accept & !consume -> skid <= input, go SKID.
  - !accept & consume -> main cleared to zero, go EMPTY.
  - neither -> hold.
- SKID:
  - in_ready = 0, so no accept.
  - consume -> main <= skid, skid cleared, go MAIN.
  - otherwise hold.
- Flush:
  - Highest priority after reset.
  - Both entries are zeroed and state goes to EMPTY at the next edge.
  - An input presented in the same cycle is discarded even if in_ready = 1; upstream must treat it as dropped.
  - A consume in the same cycle still completes downstream; the entry is not re-presented.
- Empty entries always hold all-zero payload. Instruction 0 is the codebase NOP, so an invalid output reads as a bubble.
- Payload is never modified, truncated or reordered; FIFO order is strict.
- Protocol requirements:
  - Upstream may not change in_instr/in_data or drop in_valid while in_valid & !in_ready.
  - The block does not check this.
- Reset (asynchronous, any time, including mid-transfer):
  - state EMPTY.
  - Both entries, out_instr, out_data and occupancy = 0.
  - out_valid = 0.
  - in_ready = 1 once reset deasserts; it is driven 1 from state EMPTY during reset as well.

## Timing

- Latency: an entry accepted at edge N appears on out_* after edge N, i.e. one cycle.
- Throughput: one entry per cycle sustained while out_ready = 1.
- No combinational path from any input to any output:
  - in_ready depends only on state.
  - out_* come only from the main-entry flops.
- After a one-cycle stall with in_valid held:
  - in_ready drops the cycle after the skid entry loads.
  - in_ready rises the cycle after the first consume.
- flush and reset take effect with no extra pipeline delay: one edge for flush, immediate for reset.

## Structure

- Shared package:
  - state encoding constants ST_EMPTY = 2'd0, ST_MAIN = 2'd1, ST_SKID = 2'd2.
  - NOP instruction constant (all zeros).
  - Default widths INSTR_W = 20 and DATA_W = 20.
- One sub-module is natural: stage_entry_reg.
  - Payload register of INSTR_W + NUM_DATA*DATA_W bits with async reset, load and clear.
  - Instantiated twice, for main and skid.
- The FSM and the steering muxes stay in the top module.

## Test plan

- Reset mid-stream: assert reset while occupancy = 2 with instr 0x12345 -> out_valid = 0, out_instr = 0, occupancy = 0 immediately; in_ready = 1 after release.
- Streaming: 8 entries instr 0x00001..0x00008, data lanes 0x0000A/0x000B0, with out_ready = 1 -> each appears exactly one cycle after acceptance, in order, with no gaps.
- Back-pressure: out_ready = 0 for 3 cycles while sending 0x00011, 0x00022, 0x00033 -> occupancy goes 1, then 2. in_ready = 0 and 0x00033 is held. After release, outputs are 0x00011, 0x00022, 0x00033 in order.
- Flush with occupancy 2 and in_valid = 1 (0x0ABCD) -> next cycle occupancy = 0, out_instr = 0, and 0x0ABCD never appears.
- Drain to empty: single entry 0x00055 consumed, no new input -> out_valid = 0 and out_data = 0 the following cycle.
- Parameter sweep: NUM_DATA = 3, DATA_W = 8, random valid/ready for 1000 cycles -> scoreboard shows no loss, duplication or reordering, and occupancy never exceeds 2.

Source files
------------

// File: rtl/mem_wb_skid_stage_pkg.sv
`default_nettype none
// ============================================================================
// Module      : mem_wb_skid_stage_pkg
// Description : Shared types and constants for the MEM/WB skid stage:
//               state encoding, NOP instruction and default widths.
// Revision    : 1.0 - initial release
// ============================================================================
package mem_wb_skid_stage_pkg;

  localparam int DEF_INSTR_W  = 20;
  localparam int DEF_DATA_W   = 20;
  localparam int DEF_NUM_DATA = 2;

  // Instruction word 0 is the NOP, so an empty entry reads as a bubble.
  localparam logic [DEF_INSTR_W-1:0] NOP_INSTR = '0;

  // The encoding equals the number of entries held.
  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_MAIN  = 2'd1,
    ST_SKID  = 2'd2
  } state_e;

  function automatic logic [1:0] state_occupancy(input state_e s);
    return 2'(s);
  endfunction

endpackage
`default_nettype wire

// File: rtl/mem_wb_skid_stage_entry_reg.sv
`default_nettype none
// ============================================================================
// Module      : stage_entry_reg
// Description : One payload entry (instruction + data lanes) with
//               asynchronous reset, synchronous clear and load. The clear
//               input takes priority over the load input.
// Revision    : 1.0 - initial release
// ============================================================================
module stage_entry_reg #(
  parameter int W = 60
) (
  input  logic         clock,
  input  logic         reset,
  input  logic         i_load,
  input  logic         i_clear,
  input  logic [W-1:0] i_d,
  output logic [W-1:0] o_q
);

  logic [W-1:0] r_q;

  // Payload storage: zero when empty, otherwise the last loaded value.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_q <= '0;
    end else if (i_clear) begin
      r_q <= '0;
    end else if (i_load) begin
      r_q <= i_d;
    end
  end

  assign o_q = r_q;

endmodule
`default_nettype wire

// File: rtl/mem_wb_skid_stage.sv
`default_nettype none
// ============================================================================
// Module      : mem_wb_skid_stage
// Description : MEM/WB pipeline register with valid/ready handshake, a
//               2-entry skid buffer (main + hidden skid entry) and a
//               synchronous flush. All outputs come straight from flops.
// Revision    : 1.0 - initial release
// ============================================================================
module mem_wb_skid_stage
  import mem_wb_skid_stage_pkg::*;
#(
  parameter int INSTR_W  = DEF_INSTR_W,
  parameter int DATA_W   = DEF_DATA_W,
  parameter int NUM_DATA = DEF_NUM_DATA
) (
  input  logic                       clock,
  input  logic                       reset,
  input  logic                       flush,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [INSTR_W-1:0]         in_instr,
  input  logic [NUM_DATA*DATA_W-1:0] in_data,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [INSTR_W-1:0]         out_instr,
  output logic [NUM_DATA*DATA_W-1:0] out_data,
  output logic [1:0]                 occupancy
);

  localparam int DW    = NUM_DATA * DATA_W;
  localparam int PAY_W = INSTR_W + DW;

  state_e           r_state;
  state_e           w_state_next;
  logic             w_accept;
  logic             w_consume;
  logic             w_main_load;
  logic             w_main_from_skid;
  logic             w_main_clear;
  logic             w_skid_load;
  logic             w_skid_clear;
  logic [PAY_W-1:0] w_in_pay;
  logic [PAY_W-1:0] w_main_d;
  logic [PAY_W-1:0] w_main_q;
  logic [PAY_W-1:0] w_skid_q;

  // Handshake flags are decoded from the state register only, so
  // out_ready never reaches in_ready combinationally.
  assign in_ready  = (r_state != ST_SKID);
  assign out_valid = (r_state != ST_EMPTY);
  assign occupancy = state_occupancy(r_state);

  assign w_accept  = in_valid & in_ready;
  assign w_consume = out_valid & out_ready;
  assign w_in_pay  = {in_instr, in_data};

  // State register.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_state <= ST_EMPTY;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Next state and entry steering; flush overrides every transfer.
  always_comb begin
    w_state_next     = r_state;
    w_main_load      = 1'b0;
    w_main_from_skid = 1'b0;
    w_main_clear     = 1'b0;
    w_skid_load      = 1'b0;
    w_skid_clear     = 1'b0;
    if (flush) begin
      w_state_next = ST_EMPTY;
      w_main_clear = 1'b1;
      w_skid_clear = 1'b1;
    end else begin
      case (r_state)
        ST_EMPTY: begin
          if (w_accept) begin
            w_main_load  = 1'b1;
            w_state_next = ST_MAIN;
          end
        end
        ST_MAIN: begin
          if (w_accept && w_consume) begin
            w_main_load = 1'b1;
          end else if (w_accept) begin
            w_skid_load  = 1'b1;
            w_state_next = ST_SKID;
          end else if (w_consume) begin
            w_main_clear = 1'b1;
            w_state_next = ST_EMPTY;
          end
        end
        ST_SKID: begin
          if (w_consume) begin
            w_main_load      = 1'b1;
            w_main_from_skid = 1'b1;
            w_skid_clear     = 1'b1;
            w_state_next     = ST_MAIN;
          end
        end
        default: begin
          w_main_clear = 1'b1;
          w_skid_clear = 1'b1;
          w_state_next = ST_EMPTY;
        end
      endcase
    end
  end

  assign w_main_d = w_main_from_skid ? w_skid_q : w_in_pay;

  stage_entry_reg #(.W(PAY_W)) u_main (
    .clock   (clock),
    .reset   (reset),
    .i_load  (w_main_load),
    .i_clear (w_main_clear),
    .i_d     (w_main_d),
    .o_q     (w_main_q)
  );

  stage_entry_reg #(.W(PAY_W)) u_skid (
    .clock   (clock),
    .reset   (reset),
    .i_load  (w_skid_load),
    .i_clear (w_skid_clear),
    .i_d     (w_in_pay),
    .o_q     (w_skid_q)
  );

  assign out_instr = w_main_q[PAY_W-1 -: INSTR_W];
  assign out_data  = w_main_q[DW-1:0];

endmodule
`default_nettype wire

// File: tb/tb_mem_wb_skid_stage.sv
`default_nettype none
// ============================================================================
// Module      : tb_mem_wb_skid_stage
// Description : Directed bench for mem_wb_skid_stage (default widths) plus a
//               random valid/ready run on a NUM_DATA=3, DATA_W=8 instance
//               checked against a FIFO scoreboard.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mem_wb_skid_stage;

  logic clock = 1'b0;
  logic reset;
  logic flush;
  int   n_checks = 0;
  int   n_errors = 0;

  always #5 clock = ~clock;

  // ---------------- DUT A: default widths ----------------
  logic        a_in_valid, a_in_ready, a_out_valid, a_out_ready;
  logic [19:0] a_in_instr, a_out_instr;
  logic [39:0] a_in_data, a_out_data;
  logic [1:0]  a_occ;

  mem_wb_skid_stage #(.INSTR_W(20), .DATA_W(20), .NUM_DATA(2)) u_dut_a (
    .clock(clock), .reset(reset), .flush(flush),
    .in_valid(a_in_valid), .in_ready(a_in_ready),
    .in_instr(a_in_instr), .in_data(a_in_data),
    .out_valid(a_out_valid), .out_ready(a_out_ready),
    .out_instr(a_out_instr), .out_data(a_out_data),
    .occupancy(a_occ)
  );

  // ---------------- DUT B: NUM_DATA=3, DATA_W=8 ----------------
  logic        b_flush, b_in_valid, b_in_ready, b_out_valid, b_out_ready;
  logic [19:0] b_in_instr, b_out_instr;
  logic [23:0] b_in_data, b_out_data;
  logic [1:0]  b_occ;

  mem_wb_skid_stage #(.INSTR_W(20), .DATA_W(8), .NUM_DATA(3)) u_dut_b (
    .clock(clock), .reset(reset), .flush(b_flush),
    .in_valid(b_in_valid), .in_ready(b_in_ready),
    .in_instr(b_in_instr), .in_data(b_in_data),
    .out_valid(b_out_valid), .out_ready(b_out_ready),
    .out_instr(b_out_instr), .out_data(b_out_data),
    .occupancy(b_occ)
  );

  logic [43:0] sb[$];
  logic [19:0] b_seq = 20'd1;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic drive_a(input logic v, input logic [19:0] ins, input logic [39:0] d,
                         input logic rdy);
    a_in_valid  = v;
    a_in_instr  = ins;
    a_in_data   = d;
    a_out_ready = rdy;
  endtask

  // One cycle of the random run on DUT B, with scoreboard update.
  task automatic b_cycle(input bit allow_new, input bit rdy_rand);
    logic [7:0] s;
    bit acc, con;
    if (!(b_in_valid && !b_in_ready)) begin
      b_in_valid = allow_new && ($urandom_range(0, 3) != 0);
      s          = b_seq[7:0];
      b_in_instr = b_seq;
      b_in_data  = {s ^ 8'h5A, s + 8'd1, s};
    end
    b_out_ready = rdy_rand ? ($urandom_range(0, 2) != 0) : 1'b1;
    acc = b_in_valid && b_in_ready;
    con = b_out_valid && b_out_ready;
    if (con) begin
      if (sb.size() == 0) begin
        check("b_consume_unexpected", 64'(b_out_instr), 64'hDEAD);
      end else begin
        check("b_payload", 64'({b_out_instr, b_out_data}), 64'(sb[0]));
        void'(sb.pop_front());
      end
    end
    if (acc) begin
      sb.push_back({b_in_instr, b_in_data});
      b_seq = b_seq + 20'd1;
    end
    tick();
    check("b_occ_le2", 64'(b_occ <= 2'd2), 64'd1);
    check("b_occ_model", 64'(b_occ), 64'(sb.size()));
  endtask

  localparam logic [39:0] STREAM_D = {20'h000B0, 20'h0000A};

  initial begin
    reset = 1'b0;
    flush = 1'b0;
    b_flush = 1'b0;
    b_in_valid = 1'b0; b_in_instr = '0; b_in_data = '0; b_out_ready = 1'b0;
    drive_a(1'b0, '0, '0, 1'b0);
    #1 reset = 1'b1;
    #2;
    check("rst_out_valid", 64'(a_out_valid), 64'd0);
    check("rst_occ", 64'(a_occ), 64'd0);
    check("rst_in_ready", 64'(a_in_ready), 64'd1);
    @(posedge clock);
    #1 reset = 1'b0;

    // Streaming with out_ready held high: one-cycle latency, no gaps.
    for (int i = 1; i <= 8; i++) begin
      drive_a(1'b1, 20'(i), STREAM_D, 1'b1);
      tick();
      check("stream_valid", 64'(a_out_valid), 64'd1);
      check("stream_instr", 64'(a_out_instr), 64'(i));
      check("stream_data", 64'(a_out_data), 64'(STREAM_D));
      check("stream_in_ready", 64'(a_in_ready), 64'd1);
    end
    drive_a(1'b0, '0, '0, 1'b1);
    tick();
    check("stream_end_valid", 64'(a_out_valid), 64'd0);
    check("stream_end_instr", 64'(a_out_instr), 64'd0);

    // Back-pressure for three cycles.
    drive_a(1'b1, 20'h00011, 40'h1, 1'b0);
    tick();
    check("bp_occ1", 64'(a_occ), 64'd1);
    check("bp_instr_a", 64'(a_out_instr), 64'h00011);
    drive_a(1'b1, 20'h00022, 40'h2, 1'b0);
    tick();
    check("bp_occ2", 64'(a_occ), 64'd2);
    check("bp_in_ready0", 64'(a_in_ready), 64'd0);
    drive_a(1'b1, 20'h00033, 40'h3, 1'b0);
    tick();
    check("bp_hold_occ", 64'(a_occ), 64'd2);
    check("bp_hold_instr", 64'(a_out_instr), 64'h00011);
    check("bp_hold_ready", 64'(a_in_ready), 64'd0);
    a_out_ready = 1'b1;
    tick();
    check("bp_rel_instr", 64'(a_out_instr), 64'h00022);
    check("bp_rel_occ", 64'(a_occ), 64'd1);
    check("bp_rel_ready", 64'(a_in_ready), 64'd1);
    tick();
    check("bp_third_instr", 64'(a_out_instr), 64'h00033);
    check("bp_third_data", 64'(a_out_data), 64'h3);
    drive_a(1'b0, '0, '0, 1'b1);
    tick();
    check("bp_drained", 64'(a_occ), 64'd0);

    // Flush with two entries held and an input presented.
    drive_a(1'b1, 20'h00044, 40'h4, 1'b0);
    tick();
    drive_a(1'b1, 20'h00045, 40'h5, 1'b0);
    tick();
    check("fl_pre_occ", 64'(a_occ), 64'd2);
    drive_a(1'b1, 20'h0ABCD, 40'hABCD, 1'b0);
    flush = 1'b1;
    tick();
    flush = 1'b0;
    check("fl_occ", 64'(a_occ), 64'd0);
    check("fl_instr", 64'(a_out_instr), 64'd0);
    check("fl_valid", 64'(a_out_valid), 64'd0);
    drive_a(1'b0, '0, '0, 1'b1);
    tick();
    check("fl_no_abcd", 64'(a_out_instr), 64'd0);

    // Flush with one entry and in_ready high: input still dropped.
    drive_a(1'b1, 20'h00066, 40'h6, 1'b0);
    tick();
    drive_a(1'b1, 20'h0ABCD, 40'hABCD, 1'b0);
    flush = 1'b1;
    tick();
    flush = 1'b0;
    check("fl1_occ", 64'(a_occ), 64'd0);
    check("fl1_instr", 64'(a_out_instr), 64'd0);

    // Drain to empty leaves an all-zero payload.
    drive_a(1'b1, 20'h00055, 40'h55AA, 1'b0);
    tick();
    check("dr_data", 64'(a_out_data), 64'h55AA);
    drive_a(1'b0, '0, '0, 1'b1);
    tick();
    check("dr_valid", 64'(a_out_valid), 64'd0);
    check("dr_data0", 64'(a_out_data), 64'd0);

    // Asynchronous reset while two entries are held.
    drive_a(1'b1, 20'h12345, 40'h1, 1'b0);
    tick();
    drive_a(1'b1, 20'h12346, 40'h2, 1'b0);
    tick();
    check("rm_pre_occ", 64'(a_occ), 64'd2);
    #2 reset = 1'b1;
    #1;
    check("rm_valid", 64'(a_out_valid), 64'd0);
    check("rm_instr", 64'(a_out_instr), 64'd0);
    check("rm_occ", 64'(a_occ), 64'd0);
    drive_a(1'b0, '0, '0, 1'b0);
    tick();
    reset = 1'b0;
    #1;
    check("rm_in_ready", 64'(a_in_ready), 64'd1);
    check("rm_valid_after", 64'(a_out_valid), 64'd0);

    // Random valid/ready on the 3-lane, 8-bit instance.
    for (int c = 0; c < 1000; c++) b_cycle(1'b1, 1'b1);
    for (int c = 0; c < 4; c++) b_cycle(1'b0, 1'b0);
    check("b_final_occ", 64'(b_occ), 64'd0);
    check("b_sb_empty", 64'(sb.size()), 64'd0);
    check("b_some_traffic", 64'(b_seq > 20'd100), 64'd1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire
